// File: rtl/smg_pkg.sv
// smg_pkg: shared keypad FSM states and key constants for the keypad/7-segment path.
package smg_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
    localparam logic [3:0] KEY_CLEAR = 4'hF;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
endpackage

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column divider, active-low column rotation, sample strobe and frame tick.
module keypad_col_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_out,
    output logic [1:0] col,
    output logic       sample,
    output logic       frame_tick
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            col <= '0;
        end else if (sample) begin
            div <= '0;
            col <= col + 2'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign sample     = div == DIV_LAST;
    assign frame_tick = sample && col == 2'd3;
    assign col_out    = ~(4'b0001 << col);
endmodule

// File: rtl/keypad_scan_module.sv
// keypad_scan_module: 4x4 keypad scanner with frame debounce, key event pulse and BCD entry register.
module keypad_scan_module
    import smg_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  RowIn,
    output logic [3:0]  ColOut,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic [15:0] NumberSig
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES);

    logic [3:0]    row_meta, row_sync;
    logic [15:0]   map, map_next;
    logic [1:0]    col;
    logic          sample, frame_tick;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    cand, cand_next, idx;
    logic [4:0]    ones;
    logic          none, single, accept;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk        (CLK),
        .rst_n      (RSTn),
        .col_out    (ColOut),
        .col        (col),
        .sample     (sample),
        .frame_tick (frame_tick)
    );

    // classification sees the frame including the column sampled on this very tick
    always_comb begin
        map_next = map;
        for (int r = 0; r < NUM_ROWS; r++) map_next[r * NUM_COLS + int'(col)] = ~row_sync[r];
        ones = '0;
        idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (map_next[i]) begin
                ones = ones + 5'd1;
                idx  = 4'(i);
            end
        end
    end

    assign none   = ones == 5'd0;
    assign single = ones == 5'd1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        accept     = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: if (single) begin
                    cand_next  = idx;
                    cnt_next   = CW'(1);
                    accept     = CNT_LAST == CW'(1);
                    state_next = accept ? HELD : PRESS_DB;
                end
                PRESS_DB: if (single && idx == cand) begin
                    cnt_next   = cnt + 1'b1;
                    accept     = cnt_next == CNT_LAST;
                    state_next = accept ? HELD : PRESS_DB;
                end else if (single) begin
                    cand_next = idx;
                    cnt_next  = CW'(1);
                end else begin
                    state_next = IDLE;
                end
                HELD: if (none) begin
                    cnt_next   = CW'(1);
                    state_next = CNT_LAST == CW'(1) ? IDLE : REL_DB;
                end
                REL_DB: if (none) begin
                    cnt_next   = cnt + 1'b1;
                    state_next = cnt_next == CNT_LAST ? IDLE : REL_DB;
                end else begin
                    state_next = HELD;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            map       <= '0;
            state     <= IDLE;
            cnt       <= '0;
            cand      <= '0;
            KeyValid  <= 1'b0;
            KeyCode   <= '0;
            NumberSig <= '0;
        end else begin
            row_meta <= RowIn;
            row_sync <= row_meta;
            if (sample) map <= map_next;
            state    <= state_next;
            cnt      <= cnt_next;
            cand     <= cand_next;
            KeyValid <= accept;
            if (accept) begin
                KeyCode   <= cand_next;
                NumberSig <= cand_next == KEY_CLEAR ? 16'h0000 :
                             cand_next <= 4'd9      ? {NumberSig[11:0], cand_next} : NumberSig;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_module.sv
// tb_keypad_scan_module: scoreboard bench driving a modelled key matrix against the keypad scanner.
module tb_keypad_scan_module;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [3:0]  RowIn, ColOut, KeyCode;
    logic        KeyValid;
    logic [15:0] NumberSig;
    logic [15:0] pressed = '0;
    logic [15:0] num_model = '0;
    logic [19:0] exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    keypad_scan_module #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .RowIn     (RowIn),
        .ColOut    (ColOut),
        .KeyCode   (KeyCode),
        .KeyValid  (KeyValid),
        .NumberSig (NumberSig)
    );

    always #5 CLK = ~CLK;

    // a row reads low when any pressed key in it sits on the currently driven column
    always_comb begin
        RowIn = 4'hF;
        for (int r = 0; r < 4; r++) RowIn[r] = ~|(pressed[r*4 +: 4] & ~ColOut);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (KeyValid === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_event", {28'h0, KeyCode}, 32'hDEAD);
            else check("key_event", {12'h0, KeyCode, NumberSig}, {12'h0, exp_q.pop_front()});
        end
    end

    task automatic frames(input int n);
        repeat (16 * n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_key(input logic [3:0] code);
        num_model = code == 4'hF ? 16'h0000 : code <= 4'd9 ? {num_model[11:0], code} : num_model;
        exp_q.push_back({code, num_model});
    endtask

    task automatic press(input int k, input int extra);
        pressed = 16'h1 << k;
        expect_key(4'(k));
        frames(2);
        check("early_event", 32'(exp_q.size()), 1);
        frames(1);
        @(negedge CLK);
        #1;
        check("late_event", 32'(exp_q.size()), 0);
        frames(extra);
    endtask

    task automatic release_keys(input int n);
        pressed = '0;
        frames(n);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_col", {28'h0, ColOut}, 4'b1110);
        check("rst_num", {16'h0, NumberSig}, 0);
        check("rst_kv", {31'h0, KeyValid}, 0);
        check("rst_code", {28'h0, KeyCode}, 0);
        RSTn = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("col_slot0", {28'h0, ColOut}, 4'b1110);
        @(posedge CLK);
        #1;
        check("col_slot1", {28'h0, ColOut}, 4'b1101);
        repeat (12) @(posedge CLK);
        #1;
        check("col_wrap", {28'h0, ColOut}, 4'b1110);

        press(5, 9);
        release_keys(4);
        check("t2_pending", 32'(exp_q.size()), 0);

        for (int k = 1; k <= 5; k++) begin
            press(k, 1);
            release_keys(4);
        end
        check("t3_num", {16'h0, NumberSig}, 32'h2345);

        for (int i = 0; i < 4; i++) begin
            pressed = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            frames(1);
        end
        press(6, 0);
        release_keys(2);
        pressed = 16'h0040;
        frames(2);
        release_keys(4);
        check("t4_pending", 32'(exp_q.size()), 0);

        pressed = 16'h0084;
        frames(6);
        check("t5_multi", 32'(exp_q.size()), 0);
        press(15, 0);
        release_keys(4);
        press(10, 0);
        release_keys(4);
        check("t5_num", {16'h0, NumberSig}, {16'h0, num_model});
        press(3, 0);
        release_keys(4);

        pressed = 16'h0200;
        frames(1);
        repeat (7) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        num_model = '0;
        check("t6_rst_num", {16'h0, NumberSig}, 0);
        check("t6_rst_code", {28'h0, KeyCode}, 0);
        check("t6_rst_col", {28'h0, ColOut}, 4'b1110);
        press(9, 0);
        release_keys(4);
        check("t6_pending", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
